// File: rtl/fp_mult_iter.sv
// Iterative IEEE-754 single-precision multiplier.
// The 24x24 significand product is built by one shift-add step per clock,
// then normalised and rounded (round-to-nearest-even) in a single cycle.
// Denormal inputs are treated as zero, and any NaN/Inf input gives the
// canonical quiet NaN. Zero results are always +0.
//
// state | meaning
// IDLE  | waiting for start; result holds the last product
// MUL   | 24 shift-add iterations over the significands
// NORM  | normalise, round, handle special cases
// DONE  | publish the packed result; done pulses on the following cycle
module fp_mult_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] prod_q, prod_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic signed [9:0] exp_s;
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic              guard, sticky, round_up, sign;
  logic              a_special, b_special, a_zero, b_zero;
  logic [31:0]       packed_res;

  // Normalise, round and pack the finished product held in prod_q.
  always_comb begin
    sign      = a_q[31] ^ b_q[31];
    a_special = (a_q[30:23] == 8'hFF);
    b_special = (b_q[30:23] == 8'hFF);
    a_zero    = (a_q[30:23] == 8'h00);
    b_zero    = (b_q[30:23] == 8'h00);
    exp_s     = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
    if (prod_q[47]) begin
      mant   = prod_q[47:24];
      guard  = prod_q[23];
      sticky = |prod_q[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant   = prod_q[46:23];
      guard  = prod_q[22];
      sticky = |prod_q[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    // Rounding carry-out means the significand became exactly 2.0.
    if (mant_r[24]) begin
      mant  = mant_r[24:1];
      exp_s = exp_s + 10'sd1;
    end else begin
      mant = mant_r[23:0];
    end
    if (a_special || b_special)  packed_res = 32'h7FC0_0000;
    else if (a_zero || b_zero)   packed_res = 32'h0000_0000;
    else if (exp_s >= 10'sd255)  packed_res = {sign, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0)    packed_res = 32'h0000_0000;
    else                         packed_res = {sign, exp_s[7:0], mant[22:0]};
  end

  // Next-state and datapath control for the four-state sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    pend_d   = pend_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = data_a;
          b_d      = data_b;
          mcand_d  = {24'd0, 1'b1, data_a[22:0]};
          mplier_d = {1'b1, data_b[22:0]};
          prod_d   = 48'd0;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = {mcand_q[46:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = NORM;
      end
      NORM: begin
        pend_d  = packed_res;
        state_d = DONE;
      end
      DONE: begin
        result_d = pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      prod_q   <= 48'd0;
      pend_q   <= 32'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/fp_mult_iter.md
FP_MULT_ITER -- requirements
Module: fp_mult_iter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 data_a  input  32  IEEE-754 single operand A; captured on accepted start.
REQ-006 data_b  input  32  IEEE-754 single operand B; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse when result becomes valid.
REQ-009 result  output  32  A*B in IEEE-754 single format; feeds floor_div_four.data directly.

Function
REQ-010 The state machine SHALL have four states: IDLE, MUL, NORM, DONE.
REQ-011 IDLE with start=1 at edge T SHALL capture both operands and enter MUL; start=0 SHALL hold IDLE.
REQ-012 MUL SHALL run exactly 24 cycles of shift-add over the 24-bit significands (hidden bit included), producing a 48-bit product; a 5-bit counter SHALL track iterations.
REQ-013 After the 24th MUL cycle the block SHALL spend one cycle in NORM, then one cycle in DONE, then return to IDLE.
REQ-014 Latency SHALL be fixed: start accepted at edge T -> done=1 and result valid during the cycle after edge T+26; no input value shortens it.
REQ-015 busy SHALL be 1 from the edge accepting start through the DONE cycle inclusive, 0 in IDLE.
REQ-016 start while busy=1 SHALL be ignored; operands SHALL not change mid-operation.
REQ-017 start asserted during the DONE cycle SHALL be ignored; a new start is accepted only in IDLE, giving 27-cycle back-to-back throughput.
REQ-018 result SHALL hold its value from DONE until the next DONE; it SHALL not change during MUL/NORM.
REQ-019 Sign SHALL be sign_a XOR sign_b, except for the special cases below.
REQ-020 Exponent SHALL be computed in 10-bit signed arithmetic as ea+eb-127; if product bit 47 is set, the product SHALL shift right 1 and the exponent SHALL increment.
REQ-021 Rounding SHALL be round-to-nearest-even, using a guard bit and a sticky OR of the discarded bits; a carry-out from rounding SHALL renormalise and increment the exponent.
REQ-022 Any input with exponent 0 (zero or denormal) SHALL be treated as zero, giving result 0x00000000.
REQ-023 Any input with exponent 255 SHALL give result 0x7FC00000; this case SHALL take priority over REQ-022.
REQ-024 Final exponent >= 255 SHALL give a signed infinity: sign, 0xFF, mantissa 0.
REQ-025 Final exponent <= 0 SHALL give 0x00000000, with no denormal output.
REQ-026 Every zero result SHALL be +0 (0x00000000), matching the downstream zero convention.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE and set busy=0, done=0, result=0x00000000, and clear the counter and operand registers.
REQ-028 Reset SHALL override all other inputs; reset mid-operation SHALL abort the operation without a done pulse.
REQ-029 start sampled in the same cycle as reset SHALL be ignored.

Verification
REQ-030 The bench SHALL apply 0x40000000 * 0x40400000 and check that done arrives 26 cycles after the accepting edge with result 0x40C00000, and that busy is high throughout.
REQ-031 The bench SHALL apply 0x41EC0000 * 0x3E800000 and check result 0x40EC0000; feeding this into floor_div_four SHALL give 0x3F800000.
REQ-032 The bench SHALL apply 0xBF800000 * 0x40000000 and check result 0xC0000000; it SHALL also apply 0x00000000 * 0x4555FADD and check result 0x00000000.
REQ-033 The bench SHALL apply 0x3F800001 * 0x3F800001 and check result 0x3F800002 (RNE); it SHALL also apply 0x7F000000 * 0x40000000 and check result 0x7F800000 (overflow).
REQ-034 The bench SHALL assert reset for one cycle at MUL cycle 10 and check busy=0, done=0, result=0x00000000 next cycle with no later done; a start pulsed mid-operation SHALL not disturb the result or the timing.
